dlx_decode: RTL and testbench
=============================

DLX_DECODE -- requirements
Module: dlx_decode

Interface
REQ-001 Parameter LOAD_INTERLOCK, default 1: 1 inserts a one-cycle bubble on a load-use hazard, 0 disables the interlock.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset_n  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 if_valid  in  1  fetch presents an instruction.
REQ-005 if_instr  in  32  DLX instruction word.
REQ-006 if_pc  in  32  PC of if_instr.
REQ-007 if_ready  out  1  decode accepts if_instr this cycle.
REQ-008 flush  in  1  branch taken downstream; kill all in-flight decode state.
REQ-009 ex_ready  in  1  execute consumes id_* this cycle.
REQ-010 Rs1, Rs2  out  5 each  register-file read addresses, combinational.
REQ-011 id_valid  out  1  id_* fields hold a live instruction.
REQ-012 id_rd  out  5  destination register; 0 when the instruction does not write.
REQ-013 id_wb  out  1  instruction writes the register file.
REQ-014 id_load, id_store, id_jump  out  1 each  instruction class flags.
REQ-015 id_opcode  out  6;  id_func  out  6;  id_imm  out  32  sign-extended immediate.
REQ-016 id_pc  out  32  PC of the decoded instruction.

Function
REQ-017 Field extraction: opcode = [31:26]; R-type (opcode 0): rs1 = [25:21], rs2 = [20:16], rd = [15:11], func = [5:0]; I-type: rs1 = [25:21], rd = [20:16], imm16 = [15:0]; J-type (0x02 J, 0x03 JAL): off26 = [25:0].
REQ-018 id_imm is sign-extended imm16 for I-type and sign-extended off26 for J-type; logical immediates 0x0C, 0x0D, 0x0E (ANDI, ORI, XORI) are zero-extended.
REQ-019 Loads are 0x20, 0x21, 0x23, 0x24 and 0x25; stores are 0x28, 0x29 and 0x2B; branches are 0x04 and 0x05; jumps are 0x02, 0x03, 0x12 and 0x13.
REQ-020 id_wb = 1 for R-type, loads, ALU I-type and JAL (id_rd = 31); id_wb = 0 for stores, branches, J and JR; id_wb is forced to 0 when the decoded rd = 0.
REQ-021 Rs2 for I-type stores = [20:16]; for other non-R-type instructions Rs2 = 0.
REQ-022 Rs1/Rs2 are driven from if_instr when the block is accepting, and from the held instruction otherwise, so the synchronously-read register file operands align with id_* one cycle later.
REQ-023 FSM states: EMPTY (no live output), FULL (id_valid = 1), BUBBLE (load-use stall; held instruction pending).
REQ-024 EMPTY: if_ready = 1; if if_valid is high, capture into id_* and go to FULL.
REQ-025 FULL with ex_ready = 0: hold all id_*; if_ready = 0.
REQ-026 FULL with ex_ready = 1, a new if_valid and no hazard: capture the new instruction and stay in FULL.
REQ-027 FULL with ex_ready = 1 and no new instruction: go to EMPTY.
REQ-028 Hazard: LOAD_INTERLOCK = 1, current id_load = 1, id_rd != 0, and id_rd equals the new instruction's Rs1 or Rs2 (Rs2 only where REQ-021 makes it used).
REQ-029 On a hazard with ex_ready = 1: hold the new instruction internally, set id_valid = 0 for one cycle, and go to BUBBLE.
REQ-030 BUBBLE: if_ready = 0 and Rs1/Rs2 = the held instruction's fields; next cycle move the held instruction into id_* and go to FULL.
REQ-031 A bubble is never inserted twice for the same instruction.
REQ-032 flush has priority over all other events: next state EMPTY, id_valid = 0, held instruction discarded, and the instruction offered in the same cycle is not captured; if_ready = 1 during flush.
REQ-033 Rs1 = 0 or Rs2 = 0 never raises a hazard.
REQ-034 id_* outputs are updated only on a capture edge and are stable otherwise.

Reset
REQ-035 While reset_n = 0 at posedge clk: state = EMPTY, id_valid = 0, id_wb = 0, id_load = id_store = id_jump = 0, id_rd = 0, id_opcode = 0, id_func = 0, id_imm = 0, id_pc = 0, held instruction cleared.
REQ-036 Reset asserted mid-stall or mid-hold discards all state; the first cycle after reset deasserts, if_ready = 1.

Verification
REQ-037 Reset, then ADD r3,r1,r2 (0x00221820) at pc 0x100 with ex_ready = 1 -> Rs1 = 1, Rs2 = 2 combinationally; next cycle id_valid = 1, id_rd = 3, id_wb = 1, id_pc = 0x100.
REQ-038 ADDI r5,r0,-1 (0x2005FFFF) -> id_imm = 0xFFFFFFFF, id_rd = 5; ORI r5,r0,0xFFFF (0x3405FFFF) -> id_imm = 0x0000FFFF.
REQ-039 LW r4,0(r1) followed by ADD r6,r4,r2 -> one cycle with id_valid = 0 and Rs1 = 4 held; ADD appears the next cycle; with LOAD_INTERLOCK = 0 there is no bubble.
REQ-040 ex_ready = 0 for 3 cycles while FULL -> id_* unchanged, if_ready = 0 throughout, no instruction lost or duplicated.
REQ-041 flush asserted during BUBBLE -> next cycle id_valid = 0, state EMPTY, held ADD discarded.
REQ-042 JAL (0x0C000010) -> id_rd = 31, id_wb = 1, id_imm = 0x00000010; ADD r0,r1,r2 -> id_wb = 0.

Source files
------------

// File: rtl/dlx_decode.sv
// dlx_decode: DLX instruction decode stage with a ready/valid handshake
// and an optional one-cycle load-use interlock.
module dlx_decode #(
    parameter bit LOAD_INTERLOCK = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    input  logic        flush,
    input  logic        ex_ready,
    output logic [4:0]  Rs1,
    output logic [4:0]  Rs2,
    output logic        id_valid,
    output logic [4:0]  id_rd,
    output logic        id_wb,
    output logic        id_load,
    output logic        id_store,
    output logic        id_jump,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_func,
    output logic [31:0] id_imm,
    output logic [31:0] id_pc
);
    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] FULL   = 2'd1;
    localparam logic [1:0] BUBBLE = 2'd2;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wb;
        logic        load;
        logic        store;
        logic        jump;
        logic [5:0]  opcode;
        logic [5:0]  func;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        logic [5:0] op;
        logic r, j, jal, branch, logi, alu_i, wr;
        logic [4:0] dest;
        op     = ins[31:26];
        r      = op == 6'h00;
        j      = op == 6'h02 || op == 6'h03;
        jal    = op == 6'h03;
        branch = op == 6'h04 || op == 6'h05;
        logi   = op inside {6'h0C, 6'h0D, 6'h0E};
        d.opcode = op;
        d.load   = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        d.store  = op inside {6'h28, 6'h29, 6'h2B};
        d.jump   = op inside {6'h02, 6'h03, 6'h12, 6'h13};
        alu_i    = !r && !d.load && !d.store && !branch && !d.jump;
        dest     = r ? ins[15:11] : jal ? 5'd31 : ins[20:16];
        wr       = r || d.load || alu_i || jal;
        d.wb     = wr && dest != 5'd0;
        d.rd     = d.wb ? dest : 5'd0;
        d.rs1    = j ? 5'd0 : ins[25:21];
        d.rs2    = (r || d.store) ? ins[20:16] : 5'd0;
        d.func   = r ? ins[5:0] : 6'd0;
        d.imm    = r ? 32'd0 :
                   j ? {{6{ins[25]}}, ins[25:0]} :
                   logi ? {16'd0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
        return d;
    endfunction

    logic [1:0]  state_q, state_d;
    dec_t        id_q, id_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    dec_t        dec_in, dec_pend;
    logic        full, bubble, accept, take, hazard, load_id;

    always_comb begin
        dec_in   = decode(if_instr);
        dec_pend = decode(pend_q);
        full     = state_q == FULL;
        bubble   = state_q == BUBBLE;
        accept   = state_q == EMPTY || (full && ex_ready);
        take     = accept && if_valid && !flush;
        // id_rd is nonzero only for a real write, so a zero source never matches
        hazard   = LOAD_INTERLOCK && full && id_q.load && id_q.rd != 5'd0 &&
                   (dec_in.rs1 == id_q.rd || dec_in.rs2 == id_q.rd);
        load_id  = !flush && (bubble || (take && !hazard));
        state_d  = flush ? EMPTY : bubble ? FULL :
                   take ? (hazard ? BUBBLE : FULL) : accept ? EMPTY : state_q;
        id_d     = load_id ? (bubble ? dec_pend : dec_in) : id_q;
        id_pc_d  = load_id ? (bubble ? pend_pc_q : if_pc) : id_pc_q;
        pend_d   = flush ? 32'd0 : take ? if_instr : pend_q;
        pend_pc_d = flush ? 32'd0 : take ? if_pc : pend_pc_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            id_q      <= '0;
            id_pc_q   <= '0;
            pend_q    <= '0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            id_pc_q   <= id_pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign if_ready  = flush || accept;
    assign Rs1       = if_ready ? dec_in.rs1 : dec_pend.rs1;
    assign Rs2       = if_ready ? dec_in.rs2 : dec_pend.rs2;
    assign id_valid  = full;
    assign id_rd     = id_q.rd;
    assign id_wb     = id_q.wb;
    assign id_load   = id_q.load;
    assign id_store  = id_q.store;
    assign id_jump   = id_q.jump;
    assign id_opcode = id_q.opcode;
    assign id_func   = id_q.func;
    assign id_imm    = id_q.imm;
    assign id_pc     = id_pc_q;
endmodule

// File: tb/tb_dlx_decode.sv
// tb_dlx_decode: drives an interlocked and a non-interlocked decoder with the
// same stimulus and compares both against a behavioural reference.
module tb_dlx_decode;
    logic clk = 1'b0, reset_n = 1'b0, if_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0;
    logic [31:0] if_instr = '0, if_pc = '0;
    logic [1:0] rdy, vld, wb, ld, st, jp;
    logic [1:0][4:0] r1, r2, rd;
    logic [1:0][5:0] opc, fn;
    logic [1:0][31:0] imm, pco;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    dlx_decode #(.LOAD_INTERLOCK(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(rdy[0]), .flush(flush), .ex_ready(ex_ready), .Rs1(r1[0]), .Rs2(r2[0]),
        .id_valid(vld[0]), .id_rd(rd[0]), .id_wb(wb[0]), .id_load(ld[0]), .id_store(st[0]),
        .id_jump(jp[0]), .id_opcode(opc[0]), .id_func(fn[0]), .id_imm(imm[0]), .id_pc(pco[0]));
    dlx_decode #(.LOAD_INTERLOCK(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(rdy[1]), .flush(flush), .ex_ready(ex_ready), .Rs1(r1[1]), .Rs2(r2[1]),
        .id_valid(vld[1]), .id_rd(rd[1]), .id_wb(wb[1]), .id_load(ld[1]), .id_store(st[1]),
        .id_jump(jp[1]), .id_opcode(opc[1]), .id_func(fn[1]), .id_imm(imm[1]), .id_pc(pco[1]));

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic wb, load, store, jump;
        logic [5:0] op, fn;
        logic [31:0] imm;
    } ref_t;

    // Reference decode: expected fields from the instruction classes
    function automatic ref_t ref_dec(input logic [31:0] w);
        ref_t d;
        logic [5:0] op;
        logic writes;
        logic [4:0] dst;
        op = w[31:26];
        d.op = op;
        d.load = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        d.store = op inside {6'h28, 6'h29, 6'h2B};
        d.jump = op inside {6'h02, 6'h03, 6'h12, 6'h13};
        d.rs1 = w[25:21];
        d.rs2 = 5'd0;
        d.fn = 6'd0;
        d.imm = w[15] ? 32'(w[15:0]) - 32'h10000 : 32'(w[15:0]);
        dst = w[20:16];
        writes = !(d.store || op == 6'h04 || op == 6'h05 || op == 6'h02 || op == 6'h12 || op == 6'h13);
        if (op == 6'h00) begin
            d.rs2 = w[20:16];
            dst = w[15:11];
            d.fn = w[5:0];
            d.imm = 32'd0;
        end else if (op == 6'h02 || op == 6'h03) begin
            d.rs1 = 5'd0;
            d.imm = w[25] ? 32'(w[25:0]) - 32'h4000000 : 32'(w[25:0]);
            if (op == 6'h03) dst = 5'd31;
        end
        if (d.store) d.rs2 = w[20:16];
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) d.imm = 32'(w[15:0]);
        d.wb = writes && dst != 5'd0;
        d.rd = d.wb ? dst : 5'd0;
        return d;
    endfunction

    // Model state per decoder: live instruction, and one waiting behind a bubble
    bit m_full[2], m_wait[2];
    logic [31:0] m_id[2], m_idpc[2], m_w[2], m_wpc[2];

    task automatic chk(input string tag, input int k, input logic [31:0] o, input logic [31:0] x);
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s (interlock=%0d): observed %h expected %h", tag, k, o, x);
        end
    endtask

    task automatic check_id(input int k);
        ref_t e;
        e = ref_dec(m_id[k]);
        chk("id_valid", k, 32'(vld[k]), 32'(m_full[k]));
        chk("id_rd", k, 32'(rd[k]), 32'(e.rd));
        chk("id_wb", k, 32'(wb[k]), 32'(e.wb));
        chk("id_load", k, 32'(ld[k]), 32'(e.load));
        chk("id_store", k, 32'(st[k]), 32'(e.store));
        chk("id_jump", k, 32'(jp[k]), 32'(e.jump));
        chk("id_opcode", k, 32'(opc[k]), 32'(e.op));
        chk("id_func", k, 32'(fn[k]), 32'(e.fn));
        chk("id_imm", k, imm[k], e.imm);
        chk("id_pc", k, pco[k], m_idpc[k]);
    endtask

    task automatic rst(input int n);
        @(negedge clk);
        reset_n = 1'b0;
        if_valid = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 0; m_wait[k] = 0;
            m_id[k] = '0; m_idpc[k] = '0; m_w[k] = '0; m_wpc[k] = '0;
            check_id(k);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic er, input logic fl);
        ref_t d, e, n;
        logic exp_rdy[2];
        @(negedge clk);
        reset_n = 1'b1;
        if_valid = v; if_instr = ins; if_pc = pc; ex_ready = er; flush = fl;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_rdy[k] = fl || (!m_wait[k] && (!m_full[k] || er));
            d = ref_dec(exp_rdy[k] ? ins : (m_wait[k] ? m_w[k] : m_id[k]));
            chk("if_ready", k, 32'(rdy[k]), 32'(exp_rdy[k]));
            chk("Rs1", k, 32'(r1[k]), 32'(d.rs1));
            chk("Rs2", k, 32'(r2[k]), 32'(d.rs2));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            e = ref_dec(m_id[k]);
            n = ref_dec(ins);
            if (fl) begin
                m_full[k] = 0; m_wait[k] = 0;
            end else if (m_wait[k]) begin
                m_full[k] = 1; m_wait[k] = 0; m_id[k] = m_w[k]; m_idpc[k] = m_wpc[k];
            end else if (exp_rdy[k]) begin
                if (!v) m_full[k] = 0;
                else if (k == 1 && m_full[k] && e.load && e.rd != 0 &&
                         (n.rs1 == e.rd || n.rs2 == e.rd)) begin
                    m_full[k] = 0; m_wait[k] = 1; m_w[k] = ins; m_wpc[k] = pc;
                end else begin
                    m_full[k] = 1; m_id[k] = ins; m_idpc[k] = pc;
                end
            end
            check_id(k);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D,
                                 6'h0E, 6'h12, 6'h20, 6'h23, 6'h25, 6'h28, 6'h2B};
        logic [5:0] op;
        logic [31:0] r;
        op = ops[$urandom_range(14)];
        r = $urandom;
        if (op == 6'h02 || op == 6'h03) return {op, r[25:0]};
        if (op == 6'h00)
            return {6'd0, 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)), r[10:0]};
        return {op, 5'($urandom_range(7)), 5'($urandom_range(7)), r[15:0]};
    endfunction

    localparam logic [31:0] ADD   = 32'h00221820;
    localparam logic [31:0] ADDI  = 32'h2005FFFF;
    localparam logic [31:0] ORI   = 32'h3405FFFF;
    localparam logic [31:0] LW    = 32'h8C240000;
    localparam logic [31:0] ADDU  = 32'h00823020;
    localparam logic [31:0] JAL   = 32'h0C000010;
    localparam logic [31:0] ADD0  = 32'h00220020;

    initial begin
        logic [31:0] pc;
        rst(2);
        step(1, ADD, 32'h100, 1, 0);
        step(1, ADDI, 32'h104, 1, 0);
        step(1, ORI, 32'h108, 1, 0);
        step(1, LW, 32'h10C, 1, 0);
        step(1, ADDU, 32'h110, 1, 0);
        step(1, ADD, 32'h114, 1, 0);
        step(0, ADD, 32'h118, 1, 0);
        step(1, JAL, 32'h200, 1, 0);
        repeat (3) step(1, ADD0, 32'h204, 0, 0);
        step(1, ADD0, 32'h204, 1, 0);
        step(0, 32'd0, 32'h208, 1, 0);
        step(1, LW, 32'h300, 1, 0);
        step(1, ADDU, 32'h304, 1, 0);
        step(1, ADDI, 32'h308, 1, 1);
        step(0, 32'd0, 32'h30C, 1, 0);
        step(1, LW, 32'h400, 1, 0);
        step(1, ADDU, 32'h404, 1, 0);
        rst(1);
        step(1, ADD, 32'h500, 0, 0);
        step(1, ADDI, 32'h504, 0, 0);
        rst(1);
        step(1, ORI, 32'h600, 1, 0);
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3) != 0, rand_instr(), pc, $urandom_range(9) < 7, $urandom_range(19) == 0);
            pc += 4;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
